// File: rtl/ram_cmd_pkg.sv
// -----------------------------------------------------------------------------
// ram_cmd_pkg
// Definitions shared by the RAM command initiator and the RAM itself: the
// 2-bit frame opcodes, the control-field width and the initiator FSM state
// encoding.
// -----------------------------------------------------------------------------
package ram_cmd_pkg;

   localparam int CTRL_WIDTH = 2;

   // Frame opcodes carried in the top CTRL_WIDTH bits of every command frame
   localparam logic [CTRL_WIDTH-1:0] OP_WR_ADDR = 2'b00;
   localparam logic [CTRL_WIDTH-1:0] OP_WR_DATA = 2'b01;
   localparam logic [CTRL_WIDTH-1:0] OP_RD_ADDR = 2'b10;
   localparam logic [CTRL_WIDTH-1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_ADDR = 3'd1,
      ST_WR_DATA = 3'd2,
      ST_RD_ADDR = 3'd3,
      ST_RD_CMD  = 3'd4,
      ST_RD_WAIT = 3'd5
   } state_e;

endpackage

// File: rtl/ram_cmd_timer.sv
// -----------------------------------------------------------------------------
// ram_cmd_timer
// Loadable down-counter used as the read-reply watchdog. Loading arms the
// timer; it then counts down while enabled and reports expiry once the count
// has reached zero. Clear disarms it. Clear takes priority over load.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : arm the timer with load_val_i
//   load_val_i   : start count
//   en_i         : decrement enable
//   clear_i      : disarm the timer
//   expired_o    : armed and count is zero
// -----------------------------------------------------------------------------
module ram_cmd_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic             clear_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (clear_i) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (load_i) begin
         cnt_d   = load_val_i;
         armed_d = 1'b1;
      end else if (en_i && armed_q && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign expired_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/ram_cmd_initiator.sv
// -----------------------------------------------------------------------------
// ram_cmd_initiator
// Turns single write/read requests into the 2-bit-opcode command frames the
// RAM consumes on rx_valid/din, and returns the RAM's tx_valid/dout reply as
// one response pulse. One request outstanding at a time.
//
// Optional feature macro: RAM_CMD_TIMEOUT_EN
//   defined   : a read that sees no tx_valid within TIMEOUT_CYCLES cycles of
//               entering RD_WAIT completes with rsp_err = 1, rsp_data = 0.
//   undefined : RD_WAIT waits indefinitely, rsp_err tied to 0.
//
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   req_valid/req_ready               : request handshake
//   req_write, req_addr, req_wdata    : request type, address, write data
//   rsp_valid, rsp_data, rsp_err      : response pulse, read data, timeout flag
//   cmd_valid, cmd_din                : frame to RAM rx_valid / din
//   tx_valid, dout                    : RAM read reply
// -----------------------------------------------------------------------------
module ram_cmd_initiator
   import ram_cmd_pkg::*;
#(
   parameter int MEM_DEPTH      = 256,
   parameter int ADDR_SIZE      = 8,
   parameter int WORD_SIZE      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [WORD_SIZE-1:0] rsp_data,
   output logic                 rsp_err,
   output logic                 cmd_valid,
   output logic [WORD_SIZE+1:0] cmd_din,
   input  logic                 tx_valid,
   input  logic [WORD_SIZE-1:0] dout
);

   // Parameter sanity: an address must fit in a frame payload.
   if (ADDR_SIZE > WORD_SIZE || TIMEOUT_CYCLES < 2 || MEM_DEPTH < 1) begin : g_param_chk
      $error("ram_cmd_initiator: illegal parameter combination");
   end

   state_e               state_q, state_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic [WORD_SIZE+1:0] cmd_din_q, cmd_din_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic [WORD_SIZE-1:0] addr_ext;

   always_comb begin
      addr_ext                = '0;
      addr_ext[ADDR_SIZE-1:0] = req_addr;
   end

`ifdef RAM_CMD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic rsp_err_q, rsp_err_d;
   logic timer_expired;

   // Armed on the way into RD_WAIT with TIMEOUT_CYCLES-1 so that expiry is
   // seen on the last of the TIMEOUT_CYCLES RD_WAIT cycles.
   ram_cmd_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (state_q == ST_RD_CMD),
      .load_val_i (CNT_W'(TIMEOUT_CYCLES - 1)),
      .en_i       (state_q == ST_RD_WAIT),
      .clear_i    ((state_q == ST_RD_WAIT) && (tx_valid || timer_expired)),
      .expired_o  (timer_expired)
   );
`endif

   // Frames are computed one state ahead so they leave a register in the
   // cycle that the matching state occupies.
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = 1'b0;
      cmd_din_d   = cmd_din_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      wdata_d     = wdata_q;
      req_ready   = 1'b0;
`ifdef RAM_CMD_TIMEOUT_EN
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               wdata_d     = req_wdata;
               cmd_valid_d = 1'b1;
               if (req_write) begin
                  cmd_din_d = {OP_WR_ADDR, addr_ext};
                  state_d   = ST_WR_ADDR;
               end else begin
                  cmd_din_d = {OP_RD_ADDR, addr_ext};
                  state_d   = ST_RD_ADDR;
               end
            end
         end
         ST_WR_ADDR: begin
            cmd_valid_d = 1'b1;
            cmd_din_d   = {OP_WR_DATA, wdata_q};
            state_d     = ST_WR_DATA;
         end
         ST_WR_DATA: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
`ifdef RAM_CMD_TIMEOUT_EN
            rsp_err_d   = 1'b0;
`endif
            state_d     = ST_IDLE;
         end
         ST_RD_ADDR: begin
            cmd_valid_d = 1'b1;
            cmd_din_d   = {OP_RD_DATA, {WORD_SIZE{1'b0}}};
            state_d     = ST_RD_CMD;
         end
         ST_RD_CMD: begin
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (tx_valid) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = dout;
`ifdef RAM_CMD_TIMEOUT_EN
               rsp_err_d   = 1'b0;
`endif
               state_d     = ST_IDLE;
            end
`ifdef RAM_CMD_TIMEOUT_EN
            else if (timer_expired) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_valid_q <= 1'b0;
         cmd_din_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_din_q   <= cmd_din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         wdata_q     <= wdata_d;
      end
   end

`ifdef RAM_CMD_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign cmd_valid = cmd_valid_q;
   assign cmd_din   = cmd_din_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_ram_cmd_initiator
// Directed bench for ram_cmd_initiator with a small behavioural RAM answering
// the command frames. Build with +define+RAM_CMD_TIMEOUT_EN to add the
// read-timeout scenario (TIMEOUT_CYCLES = 4).
// -----------------------------------------------------------------------------
module tb_ram_cmd_initiator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       cmd_valid;
   logic [9:0] cmd_din;
   logic       tx_valid;
   logic [7:0] dout;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Behavioural RAM: latches addresses, writes data, replies to opcode 11
   // with tx_valid held until the next read-address frame.
   logic [7:0] mem [0:255];
   logic [7:0] ram_wa, ram_ra;
   logic       force_tx_off = 1'b0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      ram_wa   = 8'h00;
      ram_ra   = 8'h00;
      tx_valid = 1'b0;
      dout     = 8'h00;
   end

   always @(posedge clk) begin
      if (cmd_valid) begin
         case (cmd_din[9:8])
            2'b00: ram_wa <= cmd_din[7:0];
            2'b01: mem[ram_wa] <= cmd_din[7:0];
            2'b10: begin ram_ra <= cmd_din[7:0]; tx_valid <= 1'b0; end
            default: if (!force_tx_off) begin tx_valid <= 1'b1; dout <= mem[ram_ra]; end
         endcase
      end
   end

   always #5 clk = ~clk;

   ram_cmd_initiator #(
      .MEM_DEPTH      (256),
      .ADDR_SIZE      (8),
      .WORD_SIZE      (8),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .cmd_valid (cmd_valid),
      .cmd_din   (cmd_din),
      .tx_valid  (tx_valid),
      .dout      (dout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
      #2;
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      vec_cnt++; if (rsp_data !== 8'h00) begin err_cnt++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
      vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
      vec_cnt++; if (cmd_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
      vec_cnt++; if (cmd_din !== 10'h000) begin err_cnt++; $display("FAIL rst_cmd_din: got %h want 000", cmd_din); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write();
      // write 0x3C <- 0xA5
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5;
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL wr_ready_idle: got %b want 1", req_ready); end
      tick();  // E0
      req_valid = 1'b0; req_wdata = 8'h00;
      vec_cnt++; if (cmd_valid !== 1'b1) begin err_cnt++; $display("FAIL wr_f0_valid: got %b want 1", cmd_valid); end
      vec_cnt++; if (cmd_din !== 10'h03C) begin err_cnt++; $display("FAIL wr_f0_din: got %h want 03c", cmd_din); end
      vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL wr_busy: got %b want 0", req_ready); end
      tick();  // E1
      vec_cnt++; if (cmd_valid !== 1'b1) begin err_cnt++; $display("FAIL wr_f1_valid: got %b want 1", cmd_valid); end
      vec_cnt++; if (cmd_din !== 10'h1A5) begin err_cnt++; $display("FAIL wr_f1_din: got %h want 1a5", cmd_din); end
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_rsp_early: got %b want 0", rsp_valid); end
      tick();  // E2
      vec_cnt++; if (cmd_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_f_end: got %b want 0", cmd_valid); end
      vec_cnt++; if (cmd_din !== 10'h1A5) begin err_cnt++; $display("FAIL wr_din_hold: got %h want 1a5", cmd_din); end
      vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL wr_rsp_valid: got %b want 1", rsp_valid); end
      vec_cnt++; if (rsp_data !== 8'h00) begin err_cnt++; $display("FAIL wr_rsp_data: got %h want 00", rsp_data); end
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL wr_ready_E2: got %b want 1", req_ready); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wr_rsp_pulse: got %b want 0", rsp_valid); end
      // write 0x00 <- 0x5A
      req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 8'h5A;
      tick();
      req_valid = 1'b0;
      vec_cnt++; if (cmd_din !== 10'h000) begin err_cnt++; $display("FAIL wr2_f0_din: got %h want 000", cmd_din); end
      tick();
      vec_cnt++; if (cmd_din !== 10'h15A) begin err_cnt++; $display("FAIL wr2_f1_din: got %h want 15a", cmd_din); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL wr2_rsp_valid: got %b want 1", rsp_valid); end
      tick();
   endtask

   task automatic test_read();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
      tick();  // E0
      req_valid = 1'b0;
      vec_cnt++; if (cmd_din !== 10'h23C || cmd_valid !== 1'b1) begin err_cnt++; $display("FAIL rd_f0: got %b/%h want 1/23c", cmd_valid, cmd_din); end
      tick();  // E1
      vec_cnt++; if (cmd_din !== 10'h300 || cmd_valid !== 1'b1) begin err_cnt++; $display("FAIL rd_f1: got %b/%h want 1/300", cmd_valid, cmd_din); end
      tick();  // E2
      vec_cnt++; if (cmd_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_wait_cmd: got %b want 0", cmd_valid); end
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rd_rsp_early: got %b want 0", rsp_valid); end
      vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL rd_busy: got %b want 0", req_ready); end
      tick();  // E3
      vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
      vec_cnt++; if (rsp_data !== 8'hA5) begin err_cnt++; $display("FAIL rd_rsp_data: got %h want a5", rsp_data); end
      vec_cnt++; if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rd_ready_E3: got %b want 1", req_ready); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b0 || rsp_data !== 8'hA5) begin err_cnt++; $display("FAIL rd_rsp_hold: got %b/%h want 0/a5", rsp_valid, rsp_data); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      tick();  // first response cycle
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin err_cnt++; $display("FAIL b2b_rsp1: got %b/%h want 1/a5", rsp_valid, rsp_data); end
      // second read issued in the same cycle as the first response
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00;
      tick();
      req_valid = 1'b0;
      vec_cnt++; if (cmd_din !== 10'h200 || cmd_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: got %b/%h want 1/200", cmd_valid, cmd_din); end
      vec_cnt++; if (rsp_valid !== 1'b0 || rsp_data !== 8'hA5) begin err_cnt++; $display("FAIL b2b_hold: got %b/%h want 0/a5", rsp_valid, rsp_data); end
      tick();
      tick();
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_stale: got %b want 0", rsp_valid); end
      tick();
      vec_cnt++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin err_cnt++; $display("FAIL b2b_rsp2: got %b/%h want 1/5a", rsp_valid, rsp_data); end
      tick();
   endtask

   task automatic test_continuous();
      logic       op_wr [4];
      logic [7:0] op_a  [4];
      logic [7:0] op_d  [4];
      logic [9:0] exp_fr [8];
      logic [7:0] exp_rsp [4];
      logic [9:0] fr_q [$];
      logic [7:0] rsp_q [$];
      int         idx;
      logic       acc;
      op_wr = '{1'b1, 1'b0, 1'b1, 1'b0};
      op_a  = '{8'h10, 8'h10, 8'h20, 8'h20};
      op_d  = '{8'h11, 8'h00, 8'h22, 8'h00};
      exp_fr  = '{10'h010, 10'h111, 10'h210, 10'h300, 10'h020, 10'h122, 10'h220, 10'h300};
      exp_rsp = '{8'h00, 8'h11, 8'h00, 8'h22};
      idx = 0;
      req_valid = 1'b1; req_write = op_wr[0]; req_addr = op_a[0]; req_wdata = op_d[0];
      for (int cyc = 0; cyc < 40 && rsp_q.size() < 4; cyc++) begin
         acc = req_valid && req_ready;
         tick();
         if (cmd_valid) fr_q.push_back(cmd_din);
         if (rsp_valid) rsp_q.push_back(rsp_data);
         if (acc) begin
            idx++;
            if (idx < 4) begin
               req_write = op_wr[idx]; req_addr = op_a[idx]; req_wdata = op_d[idx];
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      vec_cnt++; if (idx !== 4) begin err_cnt++; $display("FAIL cont_accepts: got %0d want 4", idx); end
      vec_cnt++; if (fr_q.size() !== 8) begin err_cnt++; $display("FAIL cont_frame_count: got %0d want 8", fr_q.size()); end
      for (int i = 0; i < 8; i++) begin
         vec_cnt++;
         if (i >= fr_q.size()) begin err_cnt++; $display("FAIL cont_frame%0d: got none want %h", i, exp_fr[i]); end
         else if (fr_q[i] !== exp_fr[i]) begin err_cnt++; $display("FAIL cont_frame%0d: got %h want %h", i, fr_q[i], exp_fr[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         vec_cnt++;
         if (i >= rsp_q.size()) begin err_cnt++; $display("FAIL cont_rsp%0d: got none want %h", i, exp_rsp[i]); end
         else if (rsp_q[i] !== exp_rsp[i]) begin err_cnt++; $display("FAIL cont_rsp%0d: got %h want %h", i, rsp_q[i], exp_rsp[i]); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int pulses;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
      tick();  // E0
      req_valid = 1'b0;
      tick();  // E1: RD_CMD, frame 11 on the link
      vec_cnt++; if (cmd_din !== 10'h300) begin err_cnt++; $display("FAIL rstm_pre: got %h want 300", cmd_din); end
      #1 rst_n = 1'b0;
      #1;
      vec_cnt++; if (cmd_valid !== 1'b0) begin err_cnt++; $display("FAIL rstm_cmd_valid: got %b want 0", cmd_valid); end
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstm_rsp_valid: got %b want 0", rsp_valid); end
      vec_cnt++; if (cmd_din !== 10'h000) begin err_cnt++; $display("FAIL rstm_cmd_din: got %h want 000", cmd_din); end
      #2 rst_n = 1'b1;
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rstm_ready: got %b want 1", req_ready); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid || cmd_valid) pulses++;
      end
      vec_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL rstm_no_activity: got %0d want 0", pulses); end
   endtask

`ifdef RAM_CMD_TIMEOUT_EN
   task automatic test_timeout();
      int rsp_at;
      logic [7:0] d_at;
      logic e_at;
      rsp_at = -1; d_at = 8'hFF; e_at = 1'b0;
      force_tx_off = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h3C;
      for (int n = 1; n <= 12 && rsp_at < 0; n++) begin
         tick();
         req_valid = 1'b0;
         if (rsp_valid) begin rsp_at = n; d_at = rsp_data; e_at = rsp_err; end
      end
      // accept at tick 1 (E0), RD_WAIT spans E2..E6, response visible after tick 7
      vec_cnt++; if (rsp_at !== 7) begin err_cnt++; $display("FAIL to_latency: got %0d want 7", rsp_at); end
      vec_cnt++; if (e_at !== 1'b1) begin err_cnt++; $display("FAIL to_err: got %b want 1", e_at); end
      vec_cnt++; if (d_at !== 8'h00) begin err_cnt++; $display("FAIL to_data: got %h want 00", d_at); end
      force_tx_off = 1'b0;
      tick();
      vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL to_idle: got %b want 1", req_ready); end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_continuous();
      test_reset_mid();
`ifdef RAM_CMD_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/ram_cmd_initiator.md
# ram_cmd_initiator

Initiator for the RAM command link in the SPI-slave/RAM subsystem. It accepts high-level write and read requests and sequences them into the 2-bit-opcode command frames that the RAM consumes on its `rx_valid`/`din` port. It captures the RAM's `tx_valid`/`dout` read reply and returns it as a single response. It sits where the SPI slave would otherwise drive the RAM, and serves as a local master and as a stimulus source for subsystem verification.

## Interface
- `MEM_DEPTH`, 256: RAM depth; informational, not used for logic.
- `ADDR_SIZE`, 8: address width.
- `WORD_SIZE`, 8: data width; frame width is `WORD_SIZE+2`. Requires `ADDR_SIZE <= WORD_SIZE`.
- `TIMEOUT_CYCLES`, 16: read-reply timeout, ≥2; used only with the macro below.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_SIZE`: target address.
- `req_wdata` in `WORD_SIZE`: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out `WORD_SIZE`: read data; 0 for writes.
- `rsp_err` out 1: read timed out; constant 0 without the macro.
- `cmd_valid` out 1: frame valid; drives RAM `rx_valid`.
- `cmd_din` out `WORD_SIZE+2`: frame; drives RAM `din`.
- `tx_valid` in 1: RAM read-reply valid.
- `dout` in `WORD_SIZE`: RAM read data.

## Operation
Frame encoding:
- Bits `[WORD_SIZE+1:WORD_SIZE]` carry the opcode:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data.
- The low `WORD_SIZE` bits carry the payload. An address is zero-extended. Opcode 11 carries payload 0.

FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT.
- IDLE: `req_ready` = 1, decoded combinationally from state. On accept, the request is latched. Next state is WR_ADDR if `req_write`, otherwise RD_ADDR.
- WR_ADDR: emits `{00, addr}`, then goes to WR_DATA.
- WR_DATA: emits `{01, wdata}`, pulses `rsp_valid` with `rsp_data` = 0, then goes to IDLE.
- RD_ADDR: emits `{10, addr}`, then goes to RD_CMD. This frame also clears any stale `tx_valid` at the RAM.
- RD_CMD: emits `{11, 0}`, then goes to RD_WAIT.
- RD_WAIT: `cmd_valid` = 0.
  - On the first cycle with `tx_valid` = 1, capture `dout` into `rsp_data`, pulse `rsp_valid`, and go to IDLE.
  - `tx_valid` seen in any other state is ignored.

Frame and handshake rules:
- `cmd_valid` and `cmd_din` are registered. `cmd_valid` is high for exactly one cycle per frame.
- Frames within one request are issued back-to-back.
- `cmd_din` holds its last value when `cmd_valid` = 0.
- `req_ready` = 0 in all states except IDLE, so there is never more than one outstanding request.
- Response data is registered and held until the next response.

## Timing
Take accept edge E0 (`req_valid && req_ready` sampled).
- Write:
  - Frame 00 is driven in cycle E0→E1.
  - Frame 01 is driven in cycle E1→E2.
  - `rsp_valid` is high in cycle E2→E3.
  - The next request can be accepted at E2.
- Read:
  - Frame 10 is driven in cycle E0→E1.
  - Frame 11 is driven in cycle E1→E2.
  - The RAM raises `tx_valid` at E2.
  - `rsp_valid` is high in cycle E3→E4, so read latency is 3 cycles.
  - The next request can be accepted at E3.
- Reset value of every output: `req_ready` = 1 (IDLE), `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, `cmd_valid` = 0, `cmd_din` = 0.
- Reset asserted mid-sequence aborts immediately to IDLE. The partial request is dropped and no response is issued.
- A request arriving in the same cycle as `rsp_valid` is accepted, because the FSM is already in IDLE.

## Configuration
- `RAM_CMD_TIMEOUT_EN` defined:
  - A counter runs in RD_WAIT.
  - If `tx_valid` is not seen within `TIMEOUT_CYCLES` cycles of entering RD_WAIT, the block pulses `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0, then returns to IDLE.
  - `rsp_err` is 0 on all successful responses.
- `RAM_CMD_TIMEOUT_EN` undefined:
  - No counter is built and `rsp_err` is tied to 0.
  - RD_WAIT waits indefinitely for `tx_valid`.

## Structure
- Shared package `ram_cmd_pkg` holds:
  - The opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11.
  - The FSM state encoding.
  - `CTRL_WIDTH`=2.
- The RAM uses the same opcode constants from this package.
- One optional sub-module, `ram_cmd_timer`: a loadable down-counter with clear and expire outputs, instantiated only under `RAM_CMD_TIMEOUT_EN`.

## Test plan
- Reset, then write addr 0x3C data 0xA5 → frames 0x03C then 0x1A5 on consecutive cycles; `rsp_valid` at E2 with `rsp_data` 0.
- After that write, read addr 0x3C → frames 0x23C then 0x300; `rsp_valid` 3 cycles after accept with `rsp_data` 0xA5.
- Read then read back-to-back (addr 0x3C, then 0x00 written earlier with 0x5A) → second response is 0x5A, not stale 0xA5.
- `req_valid` held high continuously with alternating write/read → accepts only in IDLE; responses are in request order; no frame overlap.
- `rst_n` pulsed low during RD_CMD → `cmd_valid` and `rsp_valid` go 0 immediately; `req_ready` is 1 after release; no response emitted.
- With `RAM_CMD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, and `tx_valid` forced 0 → `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0 after 4 RD_WAIT cycles.
